// File: rtl/time_base_pkg.sv
// Shared definitions for the time_base_gen timebase: state codes, mode codes and the
// period(td) rule used by both the RTL and its testbench.
package time_base_pkg;

   typedef logic [2:0] tb_state_t;

   localparam tb_state_t ST_IDLE   = 3'd0;
   localparam tb_state_t ST_RUN    = 3'd1;
   localparam tb_state_t ST_SINGLE = 3'd2;
   localparam tb_state_t ST_DONE   = 3'd3;
   localparam tb_state_t ST_ARMED  = 3'd4;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

   // Strobe period in sys_clk cycles for a given time/div setting.
   function automatic int unsigned tb_period(input int unsigned base_div, input int unsigned td);
      return base_div << td;
   endfunction

endpackage

// File: rtl/tb_period_cnt.sv
// Period counter for time_base_gen: owns cnt, the boundary compare, td_active latching,
// the registered sample strobe and the divided clk_out.
module tb_period_cnt
   import time_base_pkg::*;
#(
   parameter int unsigned CNT_W    = 31,
   parameter int unsigned TD_W     = 3,
   parameter int unsigned BASE_DIV = 2
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            cnt_en,
   input  logic            cnt_clr,
   input  logic            td_load,
   input  logic [TD_W-1:0] td,
   output logic            wrap,
   output logic            sample_stb,
   output logic            clk_out,
   output logic [TD_W-1:0] td_active
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_last;

   assign cnt_last = CNT_W'(tb_period(BASE_DIV, 32'(td_active)) - 32'd1);

   // A wrap already reached is honoured even if the FSM is leaving the counting states.
   assign wrap = cnt_en && (cnt_q == cnt_last);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_clr || !cnt_en || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q      <= '0;
         sample_stb <= 1'b0;
         clk_out    <= 1'b0;
         td_active  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sample_stb <= wrap;
         if (wrap) begin
            clk_out <= ~clk_out;
         end
         if (td_load || wrap) begin
            td_active <= td;
         end
      end
   end

endmodule

// File: rtl/time_base_gen.sv
// Timebase generator: sample strobe, legacy clk_out, continuous and single-shot acquisition.
// Optional external trigger (ARMED state, trig/trig_pol ports) under TIME_BASE_EXT_TRIG_EN.
module time_base_gen
   import time_base_pkg::*;
#(
   parameter int unsigned CNT_W    = 31,
   parameter int unsigned TD_W     = 3,
   parameter int unsigned SMP_W    = 12,
   parameter int unsigned BASE_DIV = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
`ifdef TIME_BASE_EXT_TRIG_EN
   input  logic             trig,
   input  logic             trig_pol,
`endif
   input  logic             en,
   input  logic [TD_W-1:0]  td,
   input  logic             mode,
   input  logic             arm,
   input  logic [SMP_W-1:0] n_samples,
   output logic             sample_stb,
   output logic             clk_out,
   output logic [TD_W-1:0]  td_active,
   output logic             busy,
   output logic             done
);

   localparam longint unsigned MAX_PER = 64'(BASE_DIV) << (2 ** TD_W - 1);

   if (BASE_DIV < 1 || MAX_PER >= (64'd1 << CNT_W)) begin : g_bad_cfg
      $error("time_base_gen: BASE_DIV << (2**TD_W-1) does not fit CNT_W bits");
   end

   tb_state_t        state_q;
   tb_state_t        state_d;
   tb_state_t        shot_tgt;
   logic [SMP_W-1:0] smp_cnt_q;
   logic [SMP_W-1:0] smp_cnt_d;
   logic             counting;
   logic             cnt_clr;
   logic             wrap;

`ifdef TIME_BASE_EXT_TRIG_EN
   logic [2:0] trig_sync_q;
   logic       trig_hit;

   // Two flops synchronise the pin, the third holds the previous level for edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         trig_sync_q <= '0;
      end else begin
         trig_sync_q <= {trig_sync_q[1:0], trig};
      end
   end

   assign trig_hit = (trig_sync_q[1] != trig_sync_q[2]) && (trig_sync_q[1] == trig_pol);
   assign shot_tgt = ST_ARMED;
`else
   assign shot_tgt = (n_samples == '0) ? ST_DONE : ST_SINGLE;
`endif

   // An exhausted single shot stops counting so no extra strobe slips out before DONE.
   assign counting = (state_q == ST_RUN) || ((state_q == ST_SINGLE) && (smp_cnt_q != '0));
   assign cnt_clr  = !((state_d == ST_RUN) || (state_d == ST_SINGLE));

   always_comb begin
      state_d   = state_q;
      smp_cnt_d = smp_cnt_q;
      if (wrap && (state_q == ST_SINGLE)) begin
         smp_cnt_d = smp_cnt_q - SMP_W'(1);
      end
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mode == MODE_CONT) begin
                  state_d = ST_RUN;
               end else if (arm) begin
                  state_d   = shot_tgt;
                  smp_cnt_d = n_samples;
               end
            end
            ST_RUN: ;
            ST_SINGLE: begin
               if (smp_cnt_q == '0) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (arm) begin
                  state_d   = shot_tgt;
                  smp_cnt_d = n_samples;
               end
            end
`ifdef TIME_BASE_EXT_TRIG_EN
            ST_ARMED: begin
               if (trig_hit) begin
                  state_d = (smp_cnt_q == '0) ? ST_DONE : ST_SINGLE;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         smp_cnt_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         smp_cnt_q <= smp_cnt_d;
         busy      <= (state_d == ST_RUN) || (state_d == ST_SINGLE) || (state_d == ST_ARMED);
         done      <= (state_d == ST_DONE);
      end
   end

   tb_period_cnt #(
      .CNT_W    (CNT_W),
      .TD_W     (TD_W),
      .BASE_DIV (BASE_DIV)
   ) u_period_cnt (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cnt_en     (counting),
      .cnt_clr    (cnt_clr),
      .td_load    (state_q == ST_IDLE),
      .td         (td),
      .wrap       (wrap),
      .sample_stb (sample_stb),
      .clk_out    (clk_out),
      .td_active  (td_active)
   );

endmodule

// File: tb/tb_time_base_gen.sv
// Self-checking bench for time_base_gen: directed scenarios plus randomized stimulus,
// checked every cycle against a deadline-based behavioural model.
module tb_time_base_gen;
   import time_base_pkg::*;

   localparam int unsigned CNT_W    = 31;
   localparam int unsigned TD_W     = 3;
   localparam int unsigned SMP_W    = 12;
   localparam int unsigned BASE_DIV = 2;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_SINGLE = 2;
   localparam int M_DONE   = 3;
   localparam int M_ARMED  = 4;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic             en;
   logic [TD_W-1:0]  td;
   logic             mode;
   logic             arm;
   logic [SMP_W-1:0] n_samples;
   logic             sample_stb;
   logic             clk_out;
   logic [TD_W-1:0]  td_active;
   logic             busy;
   logic             done;
`ifdef TIME_BASE_EXT_TRIG_EN
   logic             trig;
   logic             trig_pol;
   bit   [2:0]       m_trig_h;
`endif

   int n_chk;
   int n_bad;

   // Model: absolute cycle index plus the cycle at which the next strobe is due.
   longint t;
   longint m_deadline;
   int     m_st;
   int     m_left;
   int     m_tda;
   bit     m_clk;
   bit     e_stb;
   bit     e_busy;
   bit     e_done;

   always #5 sys_clk = ~sys_clk;

   time_base_gen #(
      .CNT_W    (CNT_W),
      .TD_W     (TD_W),
      .SMP_W    (SMP_W),
      .BASE_DIV (BASE_DIV)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
`ifdef TIME_BASE_EXT_TRIG_EN
      .trig       (trig),
      .trig_pol   (trig_pol),
`endif
      .en         (en),
      .td         (td),
      .mode       (mode),
      .arm        (arm),
      .n_samples  (n_samples),
      .sample_stb (sample_stb),
      .clk_out    (clk_out),
      .td_active  (td_active),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t          = 0;
      m_deadline = 0;
      m_st       = M_IDLE;
      m_left     = 0;
      m_tda      = 0;
      m_clk      = 1'b0;
      e_stb      = 1'b0;
      e_busy     = 1'b0;
      e_done     = 1'b0;
`ifdef TIME_BASE_EXT_TRIG_EN
      m_trig_h   = '0;
`endif
   endtask

   task automatic start_shot(output int nxt);
      m_left = int'(n_samples);
`ifdef TIME_BASE_EXT_TRIG_EN
      nxt = M_ARMED;
`else
      if (m_left == 0) begin
         nxt = M_DONE;
      end else begin
         nxt        = M_SINGLE;
         m_deadline = t + longint'(tb_period(BASE_DIV, m_tda));
      end
`endif
   endtask

   task automatic model_step();
      int old_left;
      int nxt;
      bit cnt_on;
      bit hit;
      t++;
      old_left = m_left;
      cnt_on   = (m_st == M_RUN) || (m_st == M_SINGLE && m_left != 0);
      e_stb    = cnt_on && (t == m_deadline);
      if (m_st == M_IDLE || e_stb) m_tda = int'(td);
      if (e_stb) begin
         m_clk      = !m_clk;
         m_deadline = t + longint'(tb_period(BASE_DIV, m_tda));
         if (m_st == M_SINGLE) m_left--;
      end
      hit = 1'b0;
`ifdef TIME_BASE_EXT_TRIG_EN
      hit      = (m_trig_h[1] != m_trig_h[2]) && (m_trig_h[1] == trig_pol);
      m_trig_h = {m_trig_h[1:0], trig};
`endif
      nxt = m_st;
      if (!en) begin
         nxt = M_IDLE;
      end else begin
         case (m_st)
            M_IDLE: begin
               if (mode == MODE_CONT) begin
                  nxt        = M_RUN;
                  m_deadline = t + longint'(tb_period(BASE_DIV, m_tda));
               end else if (arm) begin
                  start_shot(nxt);
               end
            end
            M_SINGLE: if (old_left == 0) nxt = M_DONE;
            M_DONE:   if (arm) start_shot(nxt);
            M_ARMED: begin
               if (hit) begin
                  if (m_left == 0) begin
                     nxt = M_DONE;
                  end else begin
                     nxt        = M_SINGLE;
                     m_deadline = t + longint'(tb_period(BASE_DIV, m_tda));
                  end
               end
            end
            default: ;
         endcase
      end
      m_st   = nxt;
      e_busy = (nxt == M_RUN) || (nxt == M_SINGLE) || (nxt == M_ARMED);
      e_done = (nxt == M_DONE);
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_step();
      #1;
      check("sample_stb", 32'(sample_stb), 32'(e_stb));
      check("clk_out", 32'(clk_out), 32'(m_clk));
      check("td_active", 32'(td_active), 32'(m_tda));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stb"}, 32'(sample_stb), 32'd0);
      check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
      check({tag, "_td_active"}, 32'(td_active), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   task automatic fire_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
`ifdef TIME_BASE_EXT_TRIG_EN
      trig = trig_pol;
      step();
      trig = ~trig_pol;
`endif
   endtask

   // One single shot: strobe count, spacing and the one-cycle done latency.
   task automatic shot(input int exp_n, input int exp_gap);
      int     got;
      bit     seen;
      longint last_t;
      fire_arm();
      got    = 0;
      last_t = -1;
      seen   = done;
      for (int i = 0; i < 2000 && !seen; i++) begin
         step();
         if (sample_stb) begin
            got++;
            if (last_t >= 0) check("shot_gap", 32'(t - last_t), 32'(exp_gap));
            last_t = t;
         end
         if (done) begin
            seen = 1'b1;
            if (exp_n > 0) check("shot_done_lat", 32'(t - last_t), 32'd1);
         end
      end
      check("shot_count", 32'(got), 32'(exp_n));
      check("shot_done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      n_chk     = 0;
      n_bad     = 0;
      en        = 1'b1;
      td        = '0;
      mode      = MODE_CONT;
      arm       = 1'b0;
      n_samples = '0;
`ifdef TIME_BASE_EXT_TRIG_EN
      trig      = 1'b0;
      trig_pol  = 1'b1;
`endif
      model_reset();
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Continuous at td=0, then td=1 with a mid-period change to td=3.
      run(10);
      td = 3'd1;
      run(9);
      td = 3'd3;
      run(40);

      // en drop mid-period, then back to continuous.
      td = 3'd0;
      run(3);
      en = 1'b0;
      step();
      en = 1'b1;
      run(7);

      // Single shots: two of five at td=2, then an empty shot.
      en = 1'b0;
      step();
      en        = 1'b1;
      mode      = MODE_SINGLE;
      td        = 3'd2;
      n_samples = 12'd5;
      shot(5, 8);
      shot(5, 8);
      n_samples = 12'd0;
      shot(0, 8);

      // Asynchronous reset in the middle of a shot, away from any clock edge.
      n_samples = 12'd5;
      fire_arm();
      run(12);
      #2 sys_rst_n = 1'b0;
      #1 check_reset_outputs("rst_async");
      model_reset();
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      run(5);

`ifdef TIME_BASE_EXT_TRIG_EN
      // A falling edge with trig_pol=1 must leave the block waiting in ARMED.
      trig_pol = 1'b1;
      trig     = 1'b1;
      run(4);
      arm = 1'b1;
      step();
      arm  = 1'b0;
      trig = 1'b0;
      run(20);
      check("armed_hold_busy", 32'(busy), 32'd1);
      trig = 1'b1;
      run(3);
      check("trig_single_busy", 32'(busy), 32'd1);
      run(60);
`endif

      for (int i = 0; i < 15000; i++) begin
         en = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 24) == 0) begin
            td = ($urandom_range(0, 7) == 0) ? TD_W'($urandom_range(0, 7))
                                             : TD_W'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         arm       = ($urandom_range(0, 7) == 0);
         n_samples = SMP_W'($urandom_range(0, 4));
`ifdef TIME_BASE_EXT_TRIG_EN
         if ($urandom_range(0, 9) == 0) trig = ~trig;
         if ($urandom_range(0, 199) == 0) trig_pol = ~trig_pol;
`endif
         step();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/time_base_gen.md
Name: time_base_gen

Overview:
- Parametrised timebase generator for the scope acquisition path; successor to the fixed 4-setting time/div divider.
- Produces a single-cycle sample strobe in the sys_clk domain plus a 50%-duty legacy clk_out.
- Supports 2**TD_W time/div settings, glitch-free setting changes, continuous and single-shot acquisition.
- Sits between the front-panel time/div control and the ADC sample/capture logic.

Parameters:
- CNT_W, 31, period counter width.
- TD_W, 3, time/div select width; 2**TD_W settings.
- SMP_W, 12, single-shot sample-count width.
- BASE_DIV, 2, strobe period in sys_clk cycles at td=0; period(td) = BASE_DIV << td. BASE_DIV >= 1.
- Elaboration-time check: BASE_DIV << (2**TD_W-1) must fit CNT_W bits.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, timebase enable.
- td, in, TD_W, requested time/div setting.
- mode, in, 1, 0 = continuous, 1 = single-shot.
- arm, in, 1, single-shot start, level-sampled in IDLE/DONE.
- n_samples, in, SMP_W, strobes per single shot, latched on arm.
- sample_stb, out, 1, one-cycle sample strobe.
- clk_out, out, 1, toggles on every sample_stb.
- td_active, out, TD_W, setting currently in force.
- busy, out, 1, high in RUN/SINGLE (and ARMED when the feature is on).
- done, out, 1, high while in DONE.

Behaviour:
- Reset is asynchronous and active-low. All flops clear on reset: state=IDLE, cnt=0, smp_cnt=0, sample_stb=0, clk_out=0, td_active=0, busy=0, done=0.
- States are IDLE, RUN, SINGLE, DONE, plus ARMED under the optional feature.
- IDLE:
  - td_active<=td every cycle; cnt held at 0.
  - en & mode=0 -> RUN.
  - en & mode=1 & arm -> SINGLE, smp_cnt<=n_samples.
  - If n_samples=0 -> DONE directly with no strobe.
- RUN/SINGLE counting:
  - cnt increments each cycle.
  - When cnt == period(td_active)-1: cnt<=0, sample_stb=1 for that single cycle, clk_out toggles, td_active<=td.
  - A td change therefore takes effect only at a period boundary; no short or long period is ever produced.
- Latency: first sample_stb is asserted period(td_active) cycles after the cycle the state enters RUN/SINGLE. Period is exact thereafter.
- SINGLE: smp_cnt decrements on each strobe. The strobe that takes smp_cnt 1->0 moves the state to DONE on the next cycle.
- DONE: done=1, cnt=0.
  - en & arm -> SINGLE with a fresh n_samples.
  - en=0 -> IDLE.
- en=0 in any state -> IDLE next cycle. cnt cleared, pending strobe dropped, clk_out holds its level.
- mode is sampled only in IDLE. A mode change in RUN/SINGLE/DONE is ignored until the state returns to IDLE.
- arm is ignored in RUN and SINGLE.
- Simultaneous en=0 and terminal strobe: the strobe is still emitted that cycle, then the state goes to IDLE (not DONE).
- Counter never exceeds period-1. No wrap-around beyond CNT_W occurs, guaranteed by the elaboration check.

Optional Feature:
- Macro: TIME_BASE_EXT_TRIG_EN.
- Defined:
  - Adds ports trig (in, 1) and trig_pol (in, 1).
  - arm in mode=1 enters ARMED. cnt is held at 0 and busy=1.
  - A 2-flop-synchronised trig edge of polarity trig_pol moves ARMED -> SINGLE.
  - Trigger latency: 3 cycles from the trig pin edge to the SINGLE state.
  - en=0 in ARMED -> IDLE.
- Not defined: no trig ports, no ARMED state; arm goes straight to SINGLE.

Decomposition:
- Package time_base_pkg holds:
  - the state enum (IDLE, RUN, SINGLE, DONE, ARMED);
  - mode constants MODE_CONT and MODE_SINGLE;
  - a function for period(td) used by both RTL and bench.
- One sub-module, tb_period_cnt, owns cnt, the boundary compare, td_active latching and sample_stb. It has a clear/enable interface to the FSM in time_base_gen.

Test Plan:
- Reset with en=1, mode=0, td=0, BASE_DIV=2 -> first sample_stb 2 cycles after RUN entry, then every 2 cycles; clk_out toggles on each strobe.
- In RUN at td=1, change td to 3 mid-period -> current 4-cycle period completes intact, then the period becomes 16; td_active updates on the boundary strobe.
- mode=1, n_samples=5, td=2, pulse arm -> exactly 5 strobes 8 cycles apart, done=1 the cycle after the 5th strobe; a second arm yields another 5.
- n_samples=0 with arm -> DONE with zero strobes; en=0 during RUN mid-period -> IDLE next cycle, no strobe, clk_out holds.
- Assert sys_rst_n low mid-SINGLE -> all outputs at reset values immediately, without waiting for sys_clk.
- With TIME_BASE_EXT_TRIG_EN, trig_pol=1: arm then rising trig -> SINGLE entered 3 cycles after the edge; a falling edge alone never leaves ARMED.
